// File: rtl/xps2_tx.sv
// xps2_tx: PS/2 host-to-device transmitter, a memory-mapped peripheral.
// The controller writes a command byte (e.g. 0xED set-LEDs, 0xFF reset).
// The block inhibits the bus, sends the start bit, eight data bits
// (LSB first), odd parity and the stop bit, clocked by the device. It then
// checks the device ack and reports the result in a 3-bit status word.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   sel, we      bus select / write enable; data_in is taken on sel&we
//   data_in[7:0] command byte
//   data_out[2:0] status {err, done, busy}, always valid
//   ps2_clk_in   sensed PS/2 clock line (asynchronous)
//   ps2_data_in  sensed PS/2 data line (asynchronous)
//   ps2_clk_oe   1 = pull PS/2 clock low
//   ps2_data_oe  1 = pull PS/2 data low
module xps2_tx #(
  parameter int unsigned INHIBIT_CYC = 5000,   // must be >= 2
  parameter int unsigned TIMEOUT_CYC = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel,
  input  logic       we,
  input  logic [7:0] data_in,
  output logic [2:0] data_out,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned INH_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE,
    S_ERR
  } state_t;

  state_t             r_state;
  logic               r_clk_meta, r_clk_sync, r_clk_prev;
  logic               r_dat_meta, r_dat_sync;
  logic [7:0]         r_byte;
  logic               r_parity;
  logic [3:0]         r_bit;
  logic [INH_W-1:0]   r_inh_cnt;
  logic [TMO_W-1:0]   r_tmo;
  logic               r_busy, r_done, r_err;
  logic               r_clk_oe, r_data_oe;

  logic w_fe;
  logic w_wr;
  logic w_tmo_run;
  logic w_tmo_hit;
  logic w_inh_pre;
  logic w_inh_last;

  // Falling edge of the synchronised device clock.
  assign w_fe       = r_clk_prev & ~r_clk_sync;
  // busy is clear exactly in IDLE, DONE and ERR, so it gates write acceptance.
  assign w_wr       = sel & we & ~r_busy;
  assign w_tmo_run  = (r_state == S_START) || (r_state == S_SEND) ||
                      (r_state == S_ACK)   || (r_state == S_WAIT_IDLE);
  assign w_tmo_hit  = w_tmo_run && (r_tmo == TMO_W'(TIMEOUT_CYC));
  assign w_inh_pre  = (r_inh_cnt == INH_W'(INHIBIT_CYC - 2));
  assign w_inh_last = (r_inh_cnt == INH_W'(INHIBIT_CYC - 1));

  assign data_out    = {r_err, r_done, r_busy};
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
      r_byte     <= '0;
      r_parity   <= 1'b0;
      r_bit      <= '0;
      r_inh_cnt  <= '0;
      r_tmo      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
    end else begin
      r_clk_meta <= ps2_clk_in;
      r_clk_sync <= r_clk_meta;
      r_clk_prev <= r_clk_sync;
      r_dat_meta <= ps2_data_in;
      r_dat_sync <= r_dat_meta;

      if (w_tmo_run) begin
        r_tmo <= r_tmo + 1'b1;
      end

      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (r_state == S_DONE) begin
            r_state <= S_IDLE;
          end
          if (w_wr) begin
            r_byte    <= data_in;
            r_parity  <= ~^data_in;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_inh_cnt <= '0;
            r_tmo     <= '0;
            r_clk_oe  <= 1'b1;
            r_data_oe <= 1'b0;
            r_state   <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          r_inh_cnt <= r_inh_cnt + 1'b1;
          // Start bit goes out one cycle before the clock is released.
          if (w_inh_pre) begin
            r_data_oe <= 1'b1;
          end
          if (w_inh_last) begin
            r_clk_oe <= 1'b0;
            r_tmo    <= '0;
            r_state  <= S_START;
          end
        end

        S_START: begin
          r_bit   <= '0;
          r_state <= S_SEND;
        end

        S_SEND: begin
          if (w_fe) begin
            if (r_bit < 4'd8) begin
              r_data_oe <= ~r_byte[r_bit[2:0]];
            end else if (r_bit == 4'd8) begin
              r_data_oe <= ~r_parity;
            end else begin
              r_data_oe <= 1'b0;
              r_state   <= S_ACK;
            end
            r_bit <= r_bit + 4'd1;
          end
        end

        S_ACK: begin
          if (w_fe) begin
            if (r_dat_sync) begin
              r_busy    <= 1'b0;
              r_err     <= 1'b1;
              r_data_oe <= 1'b0;
              r_state   <= S_ERR;
            end else begin
              r_state <= S_WAIT_IDLE;
            end
          end
        end

        S_WAIT_IDLE: begin
          if (r_clk_sync && r_dat_sync) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        default: r_state <= S_IDLE;
      endcase

      // Timeout overrides whatever the frame logic decided this cycle.
      if (w_tmo_hit) begin
        r_busy    <= 1'b0;
        r_done    <= 1'b0;
        r_err     <= 1'b1;
        r_clk_oe  <= 1'b0;
        r_data_oe <= 1'b0;
        r_state   <= S_ERR;
      end
    end
  end

endmodule

// File: tb/tb_xps2_tx.sv
// Testbench for xps2_tx: open-drain bus model with a clocking PS/2 device.
module tb_xps2_tx;

  localparam int unsigned INH = 20;
  localparam int unsigned TMO = 1500;
  localparam int unsigned HP  = 20;   // device clock half-period in clk cycles

  logic       clk = 1'b0;
  logic       rst;
  logic       sel, we;
  logic [7:0] data_in;
  logic [2:0] data_out;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low, dev_data_low;
  logic       w_clk_line, w_data_line;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] q_exp[$];

  assign w_clk_line  = ~(ps2_clk_oe  | dev_clk_low);
  assign w_data_line = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  xps2_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .we         (we),
    .data_in    (data_in),
    .data_out   (data_out),
    .ps2_clk_in (w_clk_line),
    .ps2_data_in(w_data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  task automatic bus_write(input logic [7:0] b);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; data_in = b;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  // Counts inhibit cycles (starting with the current sample) until release.
  task automatic wait_release(output int inh_len);
    int g = 0;
    inh_len = 0;
    while (!ps2_clk_oe && g < 100) begin g++; @(negedge clk); end
    while (ps2_clk_oe && inh_len < 10 * INH) begin inh_len++; @(negedge clk); end
  endtask

  task automatic dev_pulse(output logic sample);
    dev_clk_low = 1'b1;
    repeat (HP) @(negedge clk);
    sample = w_data_line;
    dev_clk_low = 1'b0;
    repeat (HP) @(negedge clk);
  endtask

  // bits[0]=start, [8:1]=data LSB first, [9]=parity, [10]=stop.
  task automatic dev_frame(input bit ack, output logic [10:0] bits, output int inh_len);
    wait_release(inh_len);
    bits[0] = w_data_line;
    repeat (HP) @(negedge clk);
    for (int i = 1; i <= 10; i++) dev_pulse(bits[i]);
    if (ack) dev_data_low = 1'b1;
    repeat (5) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HP) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (HP) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_not_busy();
    int cyc = 0;
    while (data_out[0] && cyc < 4 * TMO) begin cyc++; @(negedge clk); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (data_out !== 3'b000) $display("FAIL reset_status: got %b expected 000", data_out);
    else n_pass++;
    n_checks++;
    if (ps2_clk_oe !== 1'b0) $display("FAIL reset_clk_oe: got %b expected 0", ps2_clk_oe);
    else n_pass++;
    n_checks++;
    if (ps2_data_oe !== 1'b0) $display("FAIL reset_data_oe: got %b expected 0", ps2_data_oe);
    else n_pass++;
  endtask

  task automatic test_send_ed();
    logic [10:0] bits;
    logic [7:0]  e;
    int          inh;
    bus_write(8'hED);
    q_exp.push_back(8'hED);
    dev_frame(1'b1, bits, inh);
    e = q_exp.pop_front();
    n_checks++;
    if (inh != int'(INH)) $display("FAIL ed_inhibit_len: got %0d expected %0d", inh, INH);
    else n_pass++;
    n_checks++;
    if (bits !== {1'b1, ~^e, e, 1'b0}) $display("FAIL ed_frame: got %b expected %b", bits, {1'b1, ~^e, e, 1'b0});
    else n_pass++;
    n_checks++;
    if (bits !== 11'b1_1_11101101_0) $display("FAIL ed_frame_literal: got %b expected 11111011010", bits);
    else n_pass++;
    wait_not_busy();
    n_checks++;
    if (data_out !== 3'b010) $display("FAIL ed_status: got %b expected 010", data_out);
    else n_pass++;
  endtask

  task automatic test_parity();
    logic [7:0]  bytes[2] = '{8'h00, 8'h01};
    logic        par[2]   = '{1'b1, 1'b0};
    logic [10:0] bits;
    logic [7:0]  e;
    int          inh;
    for (int k = 0; k < 2; k++) begin
      bus_write(bytes[k]);
      q_exp.push_back(bytes[k]);
      dev_frame(1'b1, bits, inh);
      e = q_exp.pop_front();
      n_checks++;
      if (bits !== {1'b1, ~^e, e, 1'b0}) $display("FAIL parity_frame_%0d: got %b expected %b", k, bits, {1'b1, ~^e, e, 1'b0});
      else n_pass++;
      n_checks++;
      if (bits[9] !== par[k]) $display("FAIL parity_bit_%0d: got %b expected %b", k, bits[9], par[k]);
      else n_pass++;
      wait_not_busy();
      n_checks++;
      if (data_out !== 3'b010) $display("FAIL parity_status_%0d: got %b expected 010", k, data_out);
      else n_pass++;
    end
  endtask

  task automatic test_no_ack();
    logic [10:0] bits;
    logic [7:0]  e;
    int          inh;
    bus_write(8'h5A);
    q_exp.push_back(8'h5A);
    dev_frame(1'b0, bits, inh);
    e = q_exp.pop_front();
    n_checks++;
    if (bits !== {1'b1, ~^e, e, 1'b0}) $display("FAIL noack_frame: got %b expected %b", bits, {1'b1, ~^e, e, 1'b0});
    else n_pass++;
    wait_not_busy();
    n_checks++;
    if (data_out !== 3'b100) $display("FAIL noack_status: got %b expected 100", data_out);
    else n_pass++;
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) $display("FAIL noack_lines: got %b expected 00", {ps2_clk_oe, ps2_data_oe});
    else n_pass++;
  endtask

  task automatic test_timeout();
    logic [10:0] bits;
    logic [7:0]  e;
    int          inh;
    int          cyc = 0;
    bus_write(8'h12);
    wait_release(inh);
    while (!data_out[2] && cyc < int'(2 * TMO)) begin cyc++; @(negedge clk); end
    n_checks++;
    if (cyc < int'(TMO) || cyc > int'(TMO + 3)) $display("FAIL timeout_len: got %0d expected %0d..%0d", cyc, TMO, TMO + 3);
    else n_pass++;
    n_checks++;
    if (data_out !== 3'b100) $display("FAIL timeout_status: got %b expected 100", data_out);
    else n_pass++;
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) $display("FAIL timeout_lines: got %b expected 00", {ps2_clk_oe, ps2_data_oe});
    else n_pass++;
    bus_write(8'hFF);
    q_exp.push_back(8'hFF);
    n_checks++;
    if (data_out !== 3'b001) $display("FAIL after_err_write: got %b expected 001", data_out);
    else n_pass++;
    dev_frame(1'b1, bits, inh);
    e = q_exp.pop_front();
    n_checks++;
    if (bits !== {1'b1, ~^e, e, 1'b0}) $display("FAIL ff_frame: got %b expected %b", bits, {1'b1, ~^e, e, 1'b0});
    else n_pass++;
    wait_not_busy();
    n_checks++;
    if (data_out !== 3'b010) $display("FAIL ff_status: got %b expected 010", data_out);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [10:0] bits;
    logic [7:0]  e;
    int          inh;
    bus_write(8'hAA);
    q_exp.push_back(8'hAA);
    bus_write(8'h55);   // ignored: busy
    n_checks++;
    if (data_out !== 3'b001) $display("FAIL busy_status: got %b expected 001", data_out);
    else n_pass++;
    dev_frame(1'b1, bits, inh);
    e = q_exp.pop_front();
    n_checks++;
    if (bits !== {1'b1, ~^e, e, 1'b0}) $display("FAIL busy_frame: got %b expected %b", bits, {1'b1, ~^e, e, 1'b0});
    else n_pass++;
    wait_not_busy();
    n_checks++;
    if (data_out !== 3'b010) $display("FAIL busy_end_status: got %b expected 010", data_out);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [10:0] bits;
    logic [7:0]  e;
    logic        s;
    int          inh;
    bus_write(8'hE7);   // bit 4 = 0, so data_oe is pulled during bit 4
    q_exp.push_back(8'hE7);
    wait_release(inh);
    repeat (HP) @(negedge clk);
    for (int i = 0; i < 4; i++) dev_pulse(s);
    dev_clk_low = 1'b1;
    repeat (HP / 2) @(negedge clk);
    n_checks++;
    if (ps2_data_oe !== 1'b1) $display("FAIL mid_bit4_oe: got %b expected 1", ps2_data_oe);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) $display("FAIL mid_reset_lines: got %b expected 00", {ps2_clk_oe, ps2_data_oe});
    else n_pass++;
    n_checks++;
    if (data_out !== 3'b000) $display("FAIL mid_reset_status: got %b expected 000", data_out);
    else n_pass++;
    void'(q_exp.pop_front());   // aborted frame
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    bus_write(8'h3C);
    q_exp.push_back(8'h3C);
    dev_frame(1'b1, bits, inh);
    e = q_exp.pop_front();
    n_checks++;
    if (bits !== {1'b1, ~^e, e, 1'b0}) $display("FAIL post_reset_frame: got %b expected %b", bits, {1'b1, ~^e, e, 1'b0});
    else n_pass++;
    wait_not_busy();
    n_checks++;
    if (data_out !== 3'b010) $display("FAIL post_reset_status: got %b expected 010", data_out);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b0; sel = 1'b0; we = 1'b0; data_in = '0;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    test_send_ed();
    test_parity();
    test_no_ack();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/xps2_tx.md
Name: xps2_tx

Overview:
- PS/2 host-to-device transmitter; the outbound counterpart of the xps2 keyboard receiver.
- Sends a command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- Sits on the controller data bus as a memory-mapped peripheral, selected by the top-level address decoder.
- Drives the open-drain PS/2 clock and data lines through active-high pull-low enables.

Parameters:
INHIBIT_CYC, 5000, clk cycles the host holds ps2_clk low before the start bit (100 us at 50 MHz)
TIMEOUT_CYC, 750000, max clk cycles from clock release to ack sample (15 ms at 50 MHz); counter width is clog2(TIMEOUT_CYC+1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
sel  in  1  bus select from the address decoder
we  in  1  bus write enable
data_in  in  8  command byte, taken when sel&we
data_out  out  3  status {err, done, busy}
ps2_clk_in  in  1  sensed PS/2 clock line (asynchronous)
ps2_data_in  in  1  sensed PS/2 data line (asynchronous)
ps2_clk_oe  out  1  1 = pull PS/2 clock low
ps2_data_oe  out  1  1 = pull PS/2 data low

Behaviour:
- Reset (rst=0, async): state IDLE; ps2_clk_oe=0; ps2_data_oe=0; data_out=3'b000; shift register, bit count and timers cleared. Reset mid-frame releases both lines at once.
- Input synchronisation: ps2_clk_in and ps2_data_in each pass through a 2-FF synchroniser.
- Falling-edge strobe fe: synced clock goes 1 -> 0. fe is valid one cycle after the edge is registered.
- Write (sel&we):
  - In IDLE, DONE or ERR: latch data_in, compute odd parity (~^data_in), clear done and err, set busy, go to INHIBIT the next cycle.
  - Writes while busy=1 are ignored.
  - Reads have no side effect; data_out is continuously valid.
- States:
  - IDLE: both oe=0.
  - INHIBIT: ps2_clk_oe=1 for INHIBIT_CYC cycles. ps2_data_oe=1 from the last inhibit cycle onward (start bit). Then go to START.
  - START: ps2_clk_oe=0, ps2_data_oe=1. Timeout counter starts. Frame index n=0.
  - SEND, on each fe:
    - n=0..7: ps2_data_oe = ~byte[n] (LSB first).
    - n=8: ps2_data_oe = ~parity.
    - n=9: ps2_data_oe=0, releasing the line as the stop bit.
    - n increments after each fe. After the n=9 edge, go to ACK.
  - ACK: on the next fe, sample synced data. 0 -> WAIT_IDLE; 1 -> ERR (no ack).
  - WAIT_IDLE: wait until synced clk=1 and synced data=1, then DONE.
  - DONE: busy=0, done=1; go to IDLE-equivalent (accept writes).
  - ERR: busy=0, err=1, both oe=0.
- Timeout: if the counter reaches TIMEOUT_CYC in any of START, SEND, ACK or WAIT_IDLE, go to ERR.
- ps2_data_oe changes only in the cycle following fe, i.e. while the device clock is low. It never changes while ps2_clk_in is high, except at start and release.
- Status:
  - busy is 1 from the cycle after an accepted write until entry into DONE or ERR.
  - done and err are mutually exclusive and sticky until the next accepted write.
- Glitch rule: a synced-clock pulse shorter than 2 cycles may create one spurious fe. No filtering is required; the timeout/ack check covers it.

Test Plan:
- Bus-model device, clock period 80 us. Write 0xED -> ps2_clk_oe held low exactly INHIBIT_CYC cycles; device samples start=0 then bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Device acks -> data_out=3'b010.
- Write 0x00 -> parity bit sampled as 1. Write 0x01 -> parity bit sampled as 0. Both end with done=1.
- Device withholds the ack (data stays 1 at edge 11) -> data_out=3'b100; both oe=0.
- Device never clocks after release -> after TIMEOUT_CYC cycles data_out=3'b100 and lines released. A following write of 0xFF clears err and sets busy.
- Write 0xAA, then write 0x55 while busy -> the frame carries 0xAA only; the 0x55 write is ignored.
- Assert rst low during SEND bit 4 -> same cycle ps2_clk_oe=0, ps2_data_oe=0, data_out=0. After reset release, a new write transmits correctly.
